// File: rtl/debounce_pkg.sv
// Shared types and defaults for the multi-button debounce scanner.
package debounce_pkg;

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    localparam int DEF_TICK_DIV   = 26214;
    localparam int DEF_STABLE_CNT = 5;
    localparam int DEF_CNT_W      = 3;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle strobe every TICK_DIV clocks.
module tick_prescaler
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap = (r_cnt == W'(TICK_DIV - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + W'(1);
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Multi-button debouncer: one compare/increment datapath visits each button
// once per sample tick; levels, press pulses and size toggles are registered.
module debounce_scan_ctrl
    import debounce_pkg::*;
#(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic             i_run_flag,
    output logic             o_tick,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [N_BTN-1:0] o_btn_press,
    output logic [N_BTN-1:0] o_size_flag,
    output logic             o_busy
);

    localparam int IDX_W = idx_width(N_BTN);

    // A tick arriving mid-scan would be lost, so the period must cover a full scan.
    if (TICK_DIV <= N_BTN + 1) begin : g_bad_div
        $error("debounce_scan_ctrl: TICK_DIV must exceed N_BTN+1");
    end
    if (STABLE_CNT >= (1 << CNT_W)) begin : g_bad_cnt
        $error("debounce_scan_ctrl: CNT_W too narrow for STABLE_CNT");
    end

    logic                        w_tick;
    logic [N_BTN-1:0]            r_sync1, r_sync2;
    scan_state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]            r_idx, w_idx_nxt;
    logic [N_BTN-1:0][CNT_W-1:0] r_cnt;
    logic [N_BTN-1:0]            r_level, r_press, r_size;

    logic                        w_slot_s, w_slot_lvl, w_scan;
    logic [CNT_W-1:0]            w_slot_cnt;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = S_SCAN;
                    w_idx_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (r_idx == IDX_W'(N_BTN - 1)) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign w_scan     = (r_state == S_SCAN);
    assign w_slot_s   = r_sync2[r_idx];
    assign w_slot_lvl = r_level[r_idx];
    assign w_slot_cnt = r_cnt[r_idx];

    // Shared slot datapath: only the channel selected by r_idx is touched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= '0;
            r_press <= '0;
            r_size  <= '0;
        end else begin
            r_press <= '0;
            if (w_scan) begin
                if (w_slot_s == w_slot_lvl) begin
                    r_cnt[r_idx] <= '0;
                end else if (w_slot_cnt == CNT_W'(STABLE_CNT - 1)) begin
                    r_cnt[r_idx]   <= '0;
                    r_level[r_idx] <= w_slot_s;
                    if (w_slot_s) begin
                        r_press[r_idx] <= 1'b1;
                        if (!i_run_flag)
                            r_size[r_idx] <= ~r_size[r_idx];
                    end
                end else begin
                    r_cnt[r_idx] <= w_slot_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_tick      = w_tick;
    assign o_busy      = w_scan;
    assign o_btn_level = r_level;
    assign o_btn_press = r_press;
    assign o_size_flag = r_size;

endmodule
